// File: rtl/mult_arb_pkg.sv
// Shared types and default sizing for the shared 32x32 multiplier arbiter.
package mult_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } arb_state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int W_DEF       = 32;

endpackage

// File: rtl/mult32x32_arbiter_if.sv
// Bus bundle linking calculator clients and the multiplier to the arbiter.
// master = arbiter side, slave = clients plus multiplier.
interface mult32x32_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int W       = W_DEF
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [2*W-1:0]       rsp_product;
  logic                 mul_start;
  logic [W-1:0]         mul_a;
  logic [W-1:0]         mul_b;
  logic                 mul_busy;
  logic [2*W-1:0]       mul_product;

  modport master (
    input  req_valid, req_a, req_b, mul_busy, mul_product,
    output req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_a, mul_b
  );

  modport slave (
    output req_valid, req_a, req_b, mul_busy, mul_product,
    input  req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_a, mul_b
  );

endinterface

// File: rtl/mult32x32_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [IW-1:0] k;
    // NOTE: every output gets a value before any branch so no path leaves one unassigned (no latch).
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/mult32x32_arbiter.sv
// Shares one multiplier between NUM_REQ clients: round-robin grant, one
// operation in flight, product returned tagged with the owning requester id.
module mult32x32_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int W       = W_DEF
) (
  input logic                 clk,
  input logic                 reset,
  mult32x32_arbiter_if.master bus
);

  localparam int IDW = $clog2(NUM_REQ);

  arb_state_t           state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 start_q, start_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [2*W-1:0]       prod_q, prod_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [2*W-1:0]       rsp_prod_q, rsp_prod_d;

  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       win_idx;
  logic                 win_any;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Every output is a register; the comb block only computes next values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ready_d     = '0;
    start_d     = 1'b0;
    rsp_valid_d = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    prod_d      = prod_q;
    rsp_id_d    = rsp_id_q;
    rsp_prod_d  = rsp_prod_q;

    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          ready_d = grant;
          a_d     = bus.req_a[int'(win_idx)*W +: W];
          b_d     = bus.req_b[int'(win_idx)*W +: W];
          id_d    = win_idx;
          ptr_d   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start_d = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.mul_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Product is held internally so rsp_product only changes with rsp_valid.
        if (!bus.mul_busy) begin
          prod_d  = bus.mul_product;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_prod_d  = prod_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      ready_q     <= '0;
      start_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      prod_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ready_q     <= ready_d;
      start_q     <= start_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      prod_q      <= prod_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_prod_q  <= rsp_prod_d;
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.mul_start   = start_q;
  assign bus.mul_a       = a_q;
  assign bus.mul_b       = b_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_prod_q;

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Directed bench for mult32x32_arbiter with a behavioural multiplier of
// programmable busy length standing in for mult32x32_fast.
module tb_mult32x32_arbiter;
  import mult_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 200;

  logic clk;
  logic reset;

  int n_asserts = 0;
  int n_fails   = 0;
  int cyc       = 0;

  int           mul_lat = 3;
  int           mul_cnt;
  logic [W-1:0] op_a, op_b;

  int           start_cnt  = 0;
  logic         start_prev = 1'b0;
  logic [W-1:0] held_a, held_b;

  int             grant_q[$];
  int             grant_t[$];
  int             rsp_id_q[$];
  logic [2*W-1:0] rsp_prod_q[$];
  int             rsp_t[$];

  mult32x32_arbiter_if #(.NUM_REQ(NUM_REQ), .W(W)) bus ();

  mult32x32_arbiter #(.NUM_REQ(NUM_REQ), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: busy for mul_lat cycles, product scrambled until busy falls.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mul_busy    <= 1'b0;
      bus.mul_product <= '0;
      mul_cnt         <= 0;
      op_a            <= '0;
      op_b            <= '0;
    end else if (bus.mul_start) begin
      bus.mul_busy    <= 1'b1;
      bus.mul_product <= 64'hDEAD_BEEF_DEAD_BEEF;
      mul_cnt         <= mul_lat - 1;
      op_a            <= bus.mul_a;
      op_b            <= bus.mul_b;
    end else if (bus.mul_busy) begin
      if (mul_cnt == 0) begin
        bus.mul_busy    <= 1'b0;
        bus.mul_product <= {32'b0, op_a} * {32'b0, op_b};
      end else begin
        mul_cnt <= mul_cnt - 1;
      end
    end
  end

  // Event log plus continuous protocol checks.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.req_ready != '0) begin
        n_asserts++;
        if (!$onehot0(bus.req_ready)) begin
          n_fails++;
          $display("FAIL ready_onehot: req_ready=%b, required one-hot or zero", bus.req_ready);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.req_ready[i]) begin
            grant_q.push_back(i);
            grant_t.push_back(cyc);
          end
        end
      end
      if (bus.mul_start) begin
        n_asserts++;
        if (start_prev) begin
          n_fails++;
          $display("FAIL start_pulse: mul_start high 2 consecutive cycles at cycle %0d", cyc);
        end
        start_cnt++;
        held_a = bus.mul_a;
        held_b = bus.mul_b;
      end
      if (bus.mul_busy) begin
        n_asserts++;
        if (bus.mul_a !== held_a || bus.mul_b !== held_b) begin
          n_fails++;
          $display("FAIL operand_stable: mul_a=%h mul_b=%h, required %h %h", bus.mul_a, bus.mul_b, held_a, held_b);
        end
      end
      if (bus.rsp_valid) begin
        rsp_id_q.push_back(int'(bus.rsp_id));
        rsp_prod_q.push_back(bus.rsp_product);
        rsp_t.push_back(cyc);
      end
      start_prev = bus.mul_start;
    end else begin
      start_prev = 1'b0;
    end
  end

  task automatic clear_logs();
    grant_q.delete();
    grant_t.delete();
    rsp_id_q.delete();
    rsp_prod_q.delete();
    rsp_t.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One request on port p; returns id, product and grant-to-response latency.
  task automatic run_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int rid, output logic [2*W-1:0] rprod, output int lat);
    int t;
    rid   = -1;
    rprod = '0;
    lat   = -1;
    @(negedge clk);
    clear_logs();
    bus.req_a[p*W +: W] = a;
    bus.req_b[p*W +: W] = b;
    bus.req_valid[p]    = 1'b1;
    t = 0;
    while (!bus.req_ready[p] && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    bus.req_valid[p] = 1'b0;
    t = 0;
    while (rsp_id_q.size() == 0 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    n_asserts++;
    if (rsp_id_q.size() == 0 || grant_t.size() == 0) begin
      n_fails++;
      $display("FAIL op_timeout: port %0d got %0d grants, %0d responses, required 1 each", p, grant_t.size(), rsp_id_q.size());
    end else begin
      rid   = rsp_id_q[0];
      rprod = rsp_prod_q[0];
      lat   = rsp_t[0] - grant_t[0];
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (3) @(negedge clk);
    n_asserts++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.mul_start !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: ready=%b rsp_valid=%b start=%b, required all 0", bus.req_ready, bus.rsp_valid, bus.mul_start);
    end
    n_asserts++;
    if (bus.rsp_id !== '0 || bus.rsp_product !== '0 || bus.mul_a !== '0 || bus.mul_b !== '0) begin
      n_fails++;
      $display("FAIL reset_data: id=%0d prod=%h a=%h b=%h, required all 0", bus.rsp_id, bus.rsp_product, bus.mul_a, bus.mul_b);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int rid, lat, s0;
    logic [2*W-1:0] rprod;
    mul_lat = 3;
    s0 = start_cnt;
    run_op(0, 32'd315111401, 32'd318652716, rid, rprod, lat);
    repeat (4) @(negedge clk);
    n_asserts++;
    if (rid !== 0) begin
      n_fails++;
      $display("FAIL single_id: got %0d, required 0", rid);
    end
    n_asserts++;
    if (rprod !== 64'd100411103771215116) begin
      n_fails++;
      $display("FAIL single_product: got %0d, required 100411103771215116", rprod);
    end
    n_asserts++;
    if (lat != 7) begin
      n_fails++;
      $display("FAIL single_latency: got %0d cycles, required 7", lat);
    end
    n_asserts++;
    if (grant_q.size() != 1 || rsp_id_q.size() != 1 || start_cnt - s0 != 1) begin
      n_fails++;
      $display("FAIL single_pulses: ready %0d start %0d rsp %0d, required 1 each", grant_q.size(), start_cnt - s0, rsp_id_q.size());
    end
    n_asserts++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_product !== 64'd100411103771215116) begin
      n_fails++;
      $display("FAIL single_hold: rsp_valid=%b product=%0d, required 0 and held product", bus.rsp_valid, bus.rsp_product);
    end
  endtask

  task automatic test_all_four();
    int t;
    apply_reset();
    clear_logs();
    mul_lat = 2;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[i*W +: W] = W'(i + 1);
      bus.req_b[i*W +: W] = 32'd10;
    end
    bus.req_valid = '1;
    t = 0;
    while (rsp_id_q.size() < 4 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_ready[i]) bus.req_valid[i] = 1'b0;
    end
    repeat (8) @(negedge clk);
    n_asserts++;
    if (rsp_id_q.size() != 4 || grant_q.size() != 4) begin
      n_fails++;
      $display("FAIL all_count: %0d grants %0d responses, required 4 and 4", grant_q.size(), rsp_id_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_asserts++;
      if (i >= grant_q.size() || i >= rsp_id_q.size() || grant_q[i] != i || rsp_id_q[i] != i
          || rsp_prod_q[i] !== 64'((i + 1) * 10)) begin
        n_fails++;
        $display("FAIL all_order[%0d]: grant/id/product mismatch, required id %0d product %0d", i, i, (i + 1) * 10);
      end
    end
  endtask

  task automatic test_no_starvation();
    int t;
    int exp_g[4] = '{1, 2, 1, 2};
    logic [2*W-1:0] exp_p[4] = '{64'd42, 64'd45, 64'd42, 64'd45};
    mul_lat = 2;
    @(negedge clk);
    clear_logs();
    bus.req_a[1*W +: W] = 32'd7;
    bus.req_b[1*W +: W] = 32'd6;
    bus.req_a[2*W +: W] = 32'd9;
    bus.req_b[2*W +: W] = 32'd5;
    bus.req_valid[1] = 1'b1;
    bus.req_valid[2] = 1'b1;
    t = 0;
    while (grant_q.size() < 4 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    bus.req_valid[1] = 1'b0;
    bus.req_valid[2] = 1'b0;
    t = 0;
    while (rsp_id_q.size() < 4 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    repeat (8) @(negedge clk);
    n_asserts++;
    if (grant_q.size() != 4 || rsp_id_q.size() != 4) begin
      n_fails++;
      $display("FAIL rr_count: %0d grants %0d responses, required 4 and 4", grant_q.size(), rsp_id_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_asserts++;
      if (i >= grant_q.size() || i >= rsp_id_q.size() || grant_q[i] != exp_g[i]
          || rsp_id_q[i] != exp_g[i] || rsp_prod_q[i] !== exp_p[i]) begin
        n_fails++;
        $display("FAIL rr_alternate[%0d]: grant/id/product mismatch, required id %0d product %0d", i, exp_g[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_corners();
    int rid, lat;
    logic [2*W-1:0] rprod;
    mul_lat = 1;
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rid, rprod, lat);
    n_asserts++;
    if (rid !== 0 || rprod !== 64'hFFFF_FFFE_0000_0001 || lat != 5) begin
      n_fails++;
      $display("FAIL corner_ones: id %0d product %h latency %0d, required 0 fffffffe00000001 5", rid, rprod, lat);
    end
    mul_lat = 6;
    run_op(3, 32'h0000_412C, 32'h0000_37E9, rid, rprod, lat);
    n_asserts++;
    if (rid !== 3 || rprod !== 64'h0000_0000_0E3B_C50C || lat != 10) begin
      n_fails++;
      $display("FAIL corner_mixed: id %0d product %h latency %0d, required 3 0e3bc50c 10", rid, rprod, lat);
    end
    mul_lat = 2;
    run_op(1, 32'h0000_0000, 32'hFFFF_FFFF, rid, rprod, lat);
    n_asserts++;
    if (rid !== 1 || rprod !== 64'h0 || lat != 6) begin
      n_fails++;
      $display("FAIL corner_zero: id %0d product %h latency %0d, required 1 0 6", rid, rprod, lat);
    end
  endtask

  task automatic test_reset_abort();
    int t, rid, lat;
    logic [2*W-1:0] rprod;
    mul_lat = 4;
    @(negedge clk);
    clear_logs();
    bus.req_a[2*W +: W] = 32'd5;
    bus.req_b[2*W +: W] = 32'd5;
    bus.req_valid[2]    = 1'b1;
    t = 0;
    while (!bus.req_ready[2] && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    bus.req_valid[2] = 1'b0;
    t = 0;
    while (!bus.mul_busy && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_asserts++;
    if (dut.state_q !== WAIT_DONE) begin
      n_fails++;
      $display("FAIL abort_setup: state %s, required WAIT_DONE", dut.state_q.name());
    end
    reset = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.mul_start !== 1'b0 || bus.rsp_id !== '0
        || bus.rsp_product !== '0 || bus.mul_a !== '0 || bus.mul_b !== '0) begin
      n_fails++;
      $display("FAIL abort_outputs: ready=%b rsp=%b start=%b a=%h b=%h, required all 0", bus.req_ready, bus.rsp_valid, bus.mul_start, bus.mul_a, bus.mul_b);
    end
    n_asserts++;
    if (dut.state_q !== IDLE) begin
      n_fails++;
      $display("FAIL abort_state: state %s, required IDLE", dut.state_q.name());
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    n_asserts++;
    if (rsp_id_q.size() != 0 || grant_q.size() != 1) begin
      n_fails++;
      $display("FAIL abort_silent: %0d responses %0d grants, required 0 and 1", rsp_id_q.size(), grant_q.size());
    end
    run_op(2, 32'h0001_0000, 32'h0001_0000, rid, rprod, lat);
    n_asserts++;
    if (rid !== 2 || rprod !== 64'h0000_0001_0000_0000 || lat != 8) begin
      n_fails++;
      $display("FAIL abort_recover: id %0d product %h latency %0d, required 2 100000000 8", rid, rprod, lat);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before test sequence completed");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_no_starvation();
    test_corners();
    test_reset_abort();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
